array_sched: RTL and testbench
==============================

// Module: array_sched
// PURPOSE
//  Sequencer for the 4x4 output-stationary systolic array: buffers operand matrices A and B,
//  clears the array, streams skewed rows of A and columns of B, then captures the 16 results.
//  Sits between the host/load bus and the array; the only driver of the array's inputs.
// PARAMETERS
//  DATA_WIDTH  8   operand element width
//  ACC_WIDTH   16  accumulator / result element width
//  N           4   array dimension; only 4 supported (array is fixed 4x4)
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         asynchronous active-low reset
//  load_en       in   1         write one row of A or B buffer this cycle
//  load_sel      in   1         0 = A buffer (row i = A[i][*]), 1 = B buffer (row k = B[k][*])
//  load_row      in   2         row index i / k
//  load_data     in   4*DW      element e at bits [DW*(e+1)-1 : DW*e]
//  start         in   1         begin multiply C = A x B
//  busy          out  1         high in CLR/RUN/CAPT
//  res_valid     out  1         result holds a completed product
//  res_ready     in   1         host consumes result (valid&ready)
//  result        out  16*ACC    captured C, same packing as array data_out (c00 in MSBs)
//  arr_rst_n     out  1         to array rst_n: AND of rst_n and registered clear
//  arr_we        out  1         to array we
//  arr_a_in      out  4*DW      to array a_in (element r = row r)
//  arr_b_in      out  4*DW      to array b_in (element c = column c)
//  arr_data_out  in   16*ACC    from array data_out
// BEHAVIOUR
//  Reset: state IDLE; busy/res_valid/arr_we=0; arr_a_in/arr_b_in/result/t=0; buffers=0; arr_rst_n=0.
//  FSM: IDLE -start-> CLR (1 cyc) -> RUN (3N-2=10 cyc) -> CAPT (1 cyc) -> DONE.
//   DONE: res_valid=1 until res_ready (-> IDLE), or start (-> CLR, res_valid drops next cycle).
//  start honoured only in IDLE/DONE; ignored when busy. load_en honoured only in IDLE/DONE;
//   ignored when busy (buffer unchanged). load and start in same cycle: load written first, used.
//  CLR: clear register low one cycle -> arr_rst_n low for exactly one cycle; arr_we=0.
//  RUN: step counter t=0..9, arr_we=1 all 10 cycles. Registered outputs valid in cycle t:
//   arr_a_in[r] = A[r][t-r] if 0<=t-r<=3 else 0;  arr_b_in[c] = B[t-c][c] if 0<=t-c<=3 else 0.
//   Zero padding contributes 0 to every MAC; no other gating.
//  CAPT: arr_we=0, result <= arr_data_out (last MAC at PE33 lands end of t=9).
//  Latency start -> res_valid = 12 cycles. Buffers are not cleared by a run (reusable).
//  rst_n low mid-operation: immediate return to reset values; partial result discarded.
//  Arithmetic lives in PEs; controller is width-transparent, result wraps mod 2^ACC_WIDTH.
//  arr_rst_n is registered then ANDed with rst_n only; glitch-free, no combinational path from start.
// STRUCTURE
//  array_pkg: DATA_WIDTH, ACC_WIDTH, N, RUN_CYCLES=3N-2, state enum {IDLE,CLR,RUN,CAPT,DONE}.
//  Sub-module array_skew_mux: combinational select of skewed A/B elements from buffers given t;
//   instantiated once, outputs registered in array_sched.
//  Top: FSM, 4-bit step counter, 2x(4x4xDW) operand buffers, 16xACC result register.
// TESTING (bench = array_sched + array, golden model in bench)
//  A=I, B[k][c]=4k+c+1 -> result C==B (c00=1 ... c33=16), res_valid 12 cycles after start.
//  A all 2, B all 3 -> all 16 c==24; arr_rst_n low exactly 1 cycle; arr_we high exactly 10.
//  Run A all 1,B all 1 (c=4), then start in DONE without res_ready -> second result 4, not 8.
//  load_en (A row0=all 7) and start asserted during RUN -> ignored; result unchanged, busy stays.
//  rst_n low at RUN t=5 -> all outputs reset values; new load+start gives correct product.
//  res_ready held low 20 cycles in DONE -> result and res_valid stable; ready -> IDLE next cycle.

Source files
------------

// File: rtl/array_pkg.sv
// Shared constants and FSM state type for the 4x4 systolic array sequencer.
package array_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 16;
  localparam int N          = 4;
  localparam int RUN_CYCLES = 3*N - 2;
  localparam int T_W        = 4;

  typedef enum logic [2:0] {IDLE, CLR, RUN, CAPT, DONE} state_t;
endpackage

// File: rtl/array_skew_mux.sv
// Picks the diagonally skewed A-row / B-column elements fed to the array at step t.
module array_skew_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int T_W        = 4
) (
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_buf,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] b_buf,
  input  logic [T_W-1:0]                      t,
  output logic [N-1:0][DATA_WIDTH-1:0]        a_out,
  output logic [N-1:0][DATA_WIDTH-1:0]        b_out
);
  // Lane i carries A[i][k] / B[k][i] when t == i + k; outside the diagonal it is zero padding.
  always_comb begin
    a_out = '0;
    b_out = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t) == i + k) begin
          a_out[i] = a_buf[i][k];
          b_out[i] = b_buf[k][i];
        end
      end
    end
  end
endmodule

// File: rtl/array_sched.sv
// Sequencer for the 4x4 output-stationary array: operand buffers, clear, skewed streaming, capture.
module array_sched #(
  parameter int DATA_WIDTH = array_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = array_pkg::ACC_WIDTH,
  parameter int N          = array_pkg::N
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_en,
  input  logic                        load_sel,
  input  logic [1:0]                  load_row,
  input  logic [N*DATA_WIDTH-1:0]     load_data,
  input  logic                        start,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [N*N*ACC_WIDTH-1:0]    result,
  output logic                        arr_rst_n,
  output logic                        arr_we,
  output logic [N*DATA_WIDTH-1:0]     arr_a_in,
  output logic [N*DATA_WIDTH-1:0]     arr_b_in,
  input  logic [N*N*ACC_WIDTH-1:0]    arr_data_out
);
  localparam int TW         = array_pkg::T_W;
  localparam int RUN_CYCLES = 3*N - 2;

  typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;
  typedef logic [N-1:0][DATA_WIDTH-1:0]        vec_t;

  array_pkg::state_t          state_q, state_d;
  logic [TW-1:0]              t_q, t_d;
  logic                       busy_q, busy_d;
  logic                       valid_q, valid_d;
  logic                       we_q, we_d;
  logic                       clr_n_q, clr_n_d;
  vec_t                       a_in_q, a_in_d, b_in_q, b_in_d;
  logic [N*N*ACC_WIDTH-1:0]   result_q, result_d;
  mat_t                       a_buf_q, a_buf_d, b_buf_q, b_buf_d;
  logic [TW-1:0]              mux_t;
  vec_t                       mux_a, mux_b;

  // Outputs are registered, so the mux looks one step ahead of the step being driven.
  assign mux_t = (state_q == array_pkg::CLR) ? '0 : t_q + TW'(1);

  array_skew_mux #(.DATA_WIDTH(DATA_WIDTH), .N(N), .T_W(TW)) u_skew (
    .a_buf (a_buf_q),
    .b_buf (b_buf_q),
    .t     (mux_t),
    .a_out (mux_a),
    .b_out (mux_b)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    we_d     = 1'b0;
    clr_n_d  = 1'b1;
    a_in_d   = '0;
    b_in_d   = '0;
    result_d = result_q;
    a_buf_d  = a_buf_q;
    b_buf_d  = b_buf_q;

    if (load_en && (state_q == array_pkg::IDLE || state_q == array_pkg::DONE)) begin
      if (load_sel) b_buf_d[load_row] = load_data;
      else          a_buf_d[load_row] = load_data;
    end

    case (state_q)
      array_pkg::IDLE: begin
        if (start) begin
          state_d = array_pkg::CLR;
          busy_d  = 1'b1;
          clr_n_d = 1'b0;
        end
      end
      array_pkg::CLR: begin
        state_d = array_pkg::RUN;
        t_d     = '0;
        we_d    = 1'b1;
        a_in_d  = mux_a;
        b_in_d  = mux_b;
      end
      array_pkg::RUN: begin
        if (t_q == TW'(RUN_CYCLES - 1)) begin
          state_d = array_pkg::CAPT;
          t_d     = '0;
        end else begin
          t_d    = t_q + TW'(1);
          we_d   = 1'b1;
          a_in_d = mux_a;
          b_in_d = mux_b;
        end
      end
      array_pkg::CAPT: begin
        state_d  = array_pkg::DONE;
        result_d = arr_data_out;
        busy_d   = 1'b0;
        valid_d  = 1'b1;
      end
      array_pkg::DONE: begin
        // A restart wins over a simultaneous consume; the old result is dropped either way.
        if (start) begin
          state_d = array_pkg::CLR;
          busy_d  = 1'b1;
          clr_n_d = 1'b0;
          valid_d = 1'b0;
        end else if (res_ready) begin
          state_d = array_pkg::IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = array_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= array_pkg::IDLE;
      t_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      clr_n_q  <= 1'b0;
      a_in_q   <= '0;
      b_in_q   <= '0;
      result_q <= '0;
      a_buf_q  <= '0;
      b_buf_q  <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      clr_n_q  <= clr_n_d;
      a_in_q   <= a_in_d;
      b_in_q   <= b_in_d;
      result_q <= result_d;
      a_buf_q  <= a_buf_d;
      b_buf_q  <= b_buf_d;
    end
  end

  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign result    = result_q;
  assign arr_we    = we_q;
  assign arr_a_in  = a_in_q;
  assign arr_b_in  = b_in_q;
  assign arr_rst_n = rst_n & clr_n_q;
endmodule

// File: tb/tb_array_sched.sv
// Bench: array_sched driving a behavioural 4x4 output-stationary array, checked against a matrix model.
module tb_array_sched;
  localparam int DW = 8;
  localparam int AW = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         load_en = 1'b0, load_sel = 1'b0, start = 1'b0, res_ready = 1'b0;
  logic [1:0]   load_row = '0;
  logic [31:0]  load_data = '0;
  logic         busy, res_valid, arr_rst_n, arr_we;
  logic [255:0] result, arr_data_out;
  logic [31:0]  arr_a_in, arr_b_in;
  int           total = 0, bad = 0;

  always #5 clk = ~clk;

  array_sched dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_sel(load_sel), .load_row(load_row),
    .load_data(load_data), .start(start), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .arr_rst_n(arr_rst_n), .arr_we(arr_we),
    .arr_a_in(arr_a_in), .arr_b_in(arr_b_in), .arr_data_out(arr_data_out)
  );

  // Behavioural array: each PE accumulates a*b, passes a right and b down.
  logic [AW-1:0] acc [4][4];
  logic [DW-1:0] ah [4][4], bv [4][4], asrc [4][4], bsrc [4][4];

  always_comb begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (c == 0) asrc[r][c] = arr_a_in[8*r +: 8];
        else        asrc[r][c] = ah[r][c-1];
        if (r == 0) bsrc[r][c] = arr_b_in[8*c +: 8];
        else        bsrc[r][c] = bv[r-1][c];
      end
  end

  always_ff @(posedge clk or negedge arr_rst_n) begin
    if (!arr_rst_n) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc[r][c] <= '0; ah[r][c] <= '0; bv[r][c] <= '0;
        end
    end else if (arr_we) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc[r][c] <= acc[r][c] + AW'(asrc[r][c]) * AW'(bsrc[r][c]);
          ah[r][c]  <= asrc[r][c];
          bv[r][c]  <= bsrc[r][c];
        end
    end
  end

  always_comb begin
    arr_data_out = '0;
    for (int i = 0; i < 16; i++) arr_data_out[AW*(15-i) +: AW] = acc[i/4][i%4];
  end

  // Reference model: matrices, "cycles since accepted start" and the pending result.
  int           mA [4][4], mB [4][4];
  int           m_cnt = 0;
  bit           m_valid = 1'b0, m_armed = 1'b0;
  logic [255:0] m_res = '0;

  function automatic logic [255:0] matmul();
    logic [255:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) s += mA[r][k] * mB[k][c];
        v[AW*(15-(r*4+c)) +: AW] = s[15:0];
      end
    return v;
  endfunction

  function automatic logic [31:0] skew_a(int t);
    logic [31:0] v = '0;
    for (int r = 0; r < 4; r++)
      if (t - r >= 0 && t - r <= 3) begin
        int x = mA[r][t-r];
        v[8*r +: 8] = x[7:0];
      end
    return v;
  endfunction

  function automatic logic [31:0] skew_b(int t);
    logic [31:0] v = '0;
    for (int c = 0; c < 4; c++)
      if (t - c >= 0 && t - c <= 3) begin
        int x = mB[t-c][c];
        v[8*c +: 8] = x[7:0];
      end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          mA[r][c] <= 0; mB[r][c] <= 0;
        end
      m_cnt <= 0; m_valid <= 1'b0; m_armed <= 1'b0; m_res <= '0;
    end else begin
      m_armed <= 1'b1;
      if (m_cnt == 0 && load_en)
        for (int e = 0; e < 4; e++) begin
          if (load_sel) mB[load_row][e] <= int'(load_data[8*e +: 8]);
          else          mA[load_row][e] <= int'(load_data[8*e +: 8]);
        end
      if (m_cnt >= 1 && m_cnt < 12) m_cnt <= m_cnt + 1;
      else if (m_cnt == 12) begin
        m_cnt <= 0; m_valid <= 1'b1; m_res <= matmul();
      end else if (start) begin
        m_cnt <= 1; m_valid <= 1'b0;
      end else if (m_valid && res_ready) m_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_armed) begin
      chk("busy", 256'(busy), 256'(m_cnt != 0));
      chk("res_valid", 256'(res_valid), 256'(m_valid));
      chk("result", result, m_res);
      chk("arr_we", 256'(arr_we), 256'(m_cnt >= 2 && m_cnt <= 11));
      chk("arr_rst_n", 256'(arr_rst_n), 256'(m_cnt != 1));
      chk("arr_a_in", 256'(arr_a_in), (m_cnt >= 2 && m_cnt <= 11) ? 256'(skew_a(m_cnt-2)) : '0);
      chk("arr_b_in", 256'(arr_b_in), (m_cnt >= 2 && m_cnt <= 11) ? 256'(skew_b(m_cnt-2)) : '0);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic load(input bit sel, input int row, input logic [31:0] d);
    load_en = 1'b1; load_sel = sel; load_row = row[1:0]; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_fill(input logic [7:0] a, input logic [7:0] b);
    for (int r = 0; r < 4; r++) load(1'b0, r, {4{a}});
    for (int r = 0; r < 4; r++) load(1'b1, r, {4{b}});
  endtask

  // Pulse start (unless already applied) and wait for res_valid, counting clear/we cycles.
  task automatic go(input bit noise, output int lat, output int n_clr, output int n_we);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; n_clr = 0; n_we = 0;
    while (!res_valid && lat < 40) begin
      if (!arr_rst_n) n_clr++;
      if (arr_we) n_we++;
      if (noise) begin
        load_en = 1'($urandom); start = 1'($urandom); load_sel = 1'($urandom);
        load_row = 2'($urandom); load_data = $urandom;
      end
      tick();
      load_en = 1'b0; start = 1'b0;
      lat++;
    end
    if (!res_valid) chk("timeout", 256'(res_valid), 256'(1));
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  function automatic logic [255:0] fill_exp(input logic [15:0] v);
    logic [255:0] e;
    for (int i = 0; i < 16; i++) e[AW*i +: AW] = v;
    return e;
  endfunction

  initial begin
    int lat, n_clr, n_we, t_lat;
    logic [255:0] e;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_clr, n_we;
    logic [255:0] e;
    repeat (3) tick();
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_valid", 256'(res_valid), 256'(0));
    chk("rst_we", 256'(arr_we), 256'(0));
    chk("rst_arr_rst_n", 256'(arr_rst_n), 256'(0));
    chk("rst_result", result, '0);
    chk("rst_a_in", 256'({arr_a_in, arr_b_in}), 256'(0));
    rst_n = 1'b1;
    tick();

    // Identity times B = B, with c00=1 .. c33=16.
    for (int r = 0; r < 4; r++) load(1'b0, r, 32'h1 << (8*r));
    for (int k = 0; k < 4; k++) begin
      logic [31:0] d;
      for (int c = 0; c < 4; c++) d[8*c +: 8] = 8'(4*k + c + 1);
      load(1'b1, k, d);
    end
    go(1'b0, lat, n_clr, n_we);
    chk("latency", 256'(lat), 256'(12));
    e = '0;
    for (int i = 0; i < 16; i++) e[AW*(15-i) +: AW] = 16'(i + 1);
    chk("ident_result", result, e);
    consume();
    chk("after_ready_valid", 256'(res_valid), 256'(0));

    // All 2 times all 3 gives 24 everywhere.
    load_fill(8'd2, 8'd3);
    go(1'b0, lat, n_clr, n_we);
    chk("c24_result", result, fill_exp(16'd24));
    chk("clr_cycles", 256'(n_clr), 256'(1));
    chk("we_cycles", 256'(n_we), 256'(10));
    consume();

    // Restart from DONE without consuming: product is not accumulated on top.
    load_fill(8'd1, 8'd1);
    go(1'b0, lat, n_clr, n_we);
    chk("ones_result", result, fill_exp(16'd4));
    go(1'b0, lat, n_clr, n_we);
    chk("restart_latency", 256'(lat), 256'(12));
    chk("restart_result", result, fill_exp(16'd4));
    consume();

    // Load and start while running are ignored.
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    load_en = 1'b1; load_sel = 1'b0; load_row = 2'd0; load_data = 32'h07070707; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk("busy_during_run", 256'(busy), 256'(1));
    for (int i = 0; i < 40 && !res_valid; i++) tick();
    chk("ignored_load_result", result, fill_exp(16'd4));
    consume();
    go(1'b0, lat, n_clr, n_we);
    chk("buffer_kept_result", result, fill_exp(16'd4));
    consume();

    // Reset in the middle of RUN (t=5).
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0; #1;
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_we", 256'(arr_we), 256'(0));
    chk("midrst_arr_rst_n", 256'(arr_rst_n), 256'(0));
    chk("midrst_result", result, '0);
    chk("midrst_a_b_in", 256'({arr_a_in, arr_b_in}), 256'(0));
    tick();
    rst_n = 1'b1;
    tick();
    load_fill(8'd2, 8'd3);
    go(1'b0, lat, n_clr, n_we);
    chk("post_rst_result", result, fill_exp(16'd24));

    // Host stalls 20 cycles in DONE.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_result", result, fill_exp(16'd24));
      chk("stall_valid", 256'(res_valid), 256'(1));
    end
    consume();
    chk("idle_valid", 256'(res_valid), 256'(0));
    chk("idle_busy", 256'(busy), 256'(0));

    // Randomized runs; the model checks every cycle.
    for (int it = 0; it < 10; it++) begin
      for (int r = 0; r < 4; r++) load(1'b0, r, (it % 4 == 3) ? 32'hFFFFFFFF : $urandom);
      for (int r = 0; r < 4; r++) load(1'b1, r, (it % 4 == 3) ? 32'hFFFFFFFF : $urandom);
      go(1'b1, lat, n_clr, n_we);
      repeat ($urandom_range(0, 3)) tick();
      if (it % 2 == 1) begin
        // Load and start together from DONE: the new row is used.
        load_en = 1'b1; load_sel = 1'($urandom); load_row = 2'($urandom); load_data = $urandom;
        go(1'b0, lat, n_clr, n_we);
      end
      consume();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
